fifo_share_arbiter: RTL

- Round-robin arbiter that shares one circular-pointer FIFO between NREQ producers.
- Sits between the producers and the FIFO push port:
  - Grants at most one push per cycle.
  - Tags each stored word with its source ID.
  - Enforces a per-requester occupancy quota, so one producer cannot fill the FIFO.
- Watches the FIFO pop side (`fifo_pop` plus the popped tag) to return quota credits.

---
 rtl/fifo_share_arbiter_pkg.sv | 43 ++++
 rtl/fifo_share_arbiter_rr_arbiter.sv | 35 +++
 rtl/fifo_share_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_share_arbiter_pkg.sv
// Shared definitions for the FIFO-sharing arbiter and any consumer that decodes
// the {tag, payload} word written into the shared FIFO.
package fifo_share_arbiter_pkg;

  // Ceiling log2 with a minimum result of 1, used for tag and counter widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned b = 1; b < 32; b++) begin
      if ((32'd1 << w) < n) w = b + 1;
    end
    return w;
  endfunction

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_QUOTA = 4;
  localparam int unsigned DEF_IDW   = clog2(DEF_NREQ);
  localparam int unsigned DEF_CW    = clog2(DEF_QUOTA + 1);

  typedef struct packed {
    logic [DEF_IDW-1:0]   tag;
    logic [DEF_WIDTH-1:0] payload;
  } fifo_word_t;

  function automatic fifo_word_t pack_word(input logic [DEF_IDW-1:0] tag,
                                           input logic [DEF_WIDTH-1:0] payload);
    fifo_word_t w;
    w.tag     = tag;
    w.payload = payload;
    return w;
  endfunction

  function automatic logic [DEF_IDW-1:0] unpack_tag(input fifo_word_t w);
    return w.tag;
  endfunction

  function automatic logic [DEF_WIDTH-1:0] unpack_payload(input fifo_word_t w);
    return w.payload;
  endfunction

endpackage

// File: rtl/fifo_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index starting at rr_ptr_i,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  win_o
);

  int unsigned    idx;
  logic [IDW-1:0] idx_w;
  logic           found;

  always_comb begin
    grant_o = '0;
    win_o   = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!found && elig_i[idx_w]) begin
        found          = 1'b1;
        grant_o[idx_w] = 1'b1;
        win_o          = idx_w;
      end
    end
  end

endmodule

// File: rtl/fifo_share_arbiter.sv
// Round-robin push arbiter in front of a shared FIFO; tags each word with its
// source and limits per-requester occupancy, reclaiming credits on pop.
module fifo_share_arbiter
  import fifo_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned IDW   = DEF_IDW,
  parameter int unsigned QUOTA = DEF_QUOTA,
  parameter int unsigned CW    = DEF_CW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [WIDTH+IDW-1:0]  fifo_data_in,
  input  logic                  fifo_pop,
  input  logic [IDW-1:0]        fifo_pop_tag,
  output logic [NREQ*CW-1:0]    occ_cnt,
  output logic                  err_underflow
);

  if ((DEPTH & (DEPTH - 1)) != 0 || QUOTA < 1 || QUOTA > DEPTH || NREQ < 2 || NREQ > 16)
  begin : g_bad_params
    $error("fifo_share_arbiter: illegal parameter combination");
  end

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    occ_q [NREQ];
  logic [CW-1:0]    occ_d [NREQ];
  logic             err_q, err_d;
  logic [NREQ-1:0]  elig, grant, pop_hit;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] win_payload;
  logic             underflow;

  // Eligibility and pop-tag decode; rst masks all grants.
  always_comb begin
    elig    = '0;
    pop_hit = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pop_hit[i] = fifo_pop && (fifo_pop_tag == IDW'(i));
      elig[i]    = req_valid[i] && (occ_q[i] < CW'(QUOTA)) && !fifo_full && !rst;
    end
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
    .elig_i  (elig),
    .rr_ptr_i(rr_ptr_q),
    .grant_o (grant),
    .win_o   (win)
  );

  always_comb begin
    win_payload = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) win_payload = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign req_ready     = grant;
  assign fifo_push     = |grant;
  assign fifo_data_in  = fifo_push ? {win, win_payload} : '0;
  assign err_underflow = err_q;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) occ_cnt[i*CW +: CW] = occ_q[i];
  end

  // Next-state: pointer advance, credit accounting, sticky underflow.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    underflow = fifo_pop;
    for (int unsigned i = 0; i < NREQ; i++) occ_d[i] = occ_q[i];
    if (fifo_push) rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pop_hit[i] && occ_q[i] != '0) underflow = 1'b0;
      case ({grant[i], pop_hit[i] && occ_q[i] != '0})
        2'b10:   occ_d[i] = occ_q[i] + CW'(1);
        2'b01:   occ_d[i] = occ_q[i] - CW'(1);
        default: occ_d[i] = occ_q[i];
      endcase
    end
    err_d = err_q | underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) occ_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < NREQ; i++) occ_q[i] <= occ_d[i];
    end
  end

endmodule
